// File: rtl/fifo_almost_full_tx.sv
// fifo_almost_full_tx
// Drains a first-word-fall-through source FIFO into the write port of a
// downstream almost-full FIFO across a register-retimed long path. The
// forward pipe never stalls. Words already in flight when the downstream
// side reports almost-full land in the downstream FIFO's grace slots.
// The returned full_n is retimed by BACK_DEPTH registers before it gates
// source reads.
module fifo_almost_full_tx #(
    parameter int DATA_WIDTH = 32,
    parameter int PIPE_DEPTH = 2,
    parameter int BACK_DEPTH = 1,
    parameter int DST_GRACE  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  src_empty_n,
    input  logic [DATA_WIDTH-1:0] src_dout,
    output logic                  src_read,
    input  logic                  dst_full_n,
    output logic                  dst_write,
    output logic [DATA_WIDTH-1:0] dst_din,
    output logic [31:0]           sent_count,
    output logic                  idle
);

    // The downstream grace slots must cover every word that can still be
    // written after its almost-full asserts.
    if (PIPE_DEPTH < 1) begin : g_bad_pipe
        $error("fifo_almost_full_tx: PIPE_DEPTH must be at least 1");
    end
    if (BACK_DEPTH < 0) begin : g_bad_back
        $error("fifo_almost_full_tx: BACK_DEPTH must not be negative");
    end
    if (DST_GRACE < PIPE_DEPTH + BACK_DEPTH + 1) begin : g_bad_grace
        $error("fifo_almost_full_tx: DST_GRACE must be >= PIPE_DEPTH+BACK_DEPTH+1");
    end

    logic                  full_ok_s;
    logic [PIPE_DEPTH-1:0] valid_q;
    logic [PIPE_DEPTH-1:0] valid_d;
    logic [DATA_WIDTH-1:0] data_q [PIPE_DEPTH];
    logic [DATA_WIDTH-1:0] data_d [PIPE_DEPTH];
    logic [31:0]           sent_count_q;
    logic [31:0]           sent_count_d;

    // Return path: either use full_n directly or through a reset-to-full chain.
    if (BACK_DEPTH == 0) begin : g_no_back
        assign full_ok_s = dst_full_n;
    end else begin : g_back
        logic [BACK_DEPTH-1:0] full_q;
        logic [BACK_DEPTH-1:0] full_d;

        // Shift the returned full_n one stage per cycle.
        always_comb begin
            full_d    = full_q;
            full_d[0] = dst_full_n;
            for (int k = 1; k < BACK_DEPTH; k++) begin
                full_d[k] = full_q[k-1];
            end
        end

        // Chain resets to "no space" so nothing is read until the
        // downstream FIFO has reported room.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                full_q <= '0;
            end else begin
                full_q <= full_d;
            end
        end

        assign full_ok_s = full_q[BACK_DEPTH-1];
    end

    // Pop the source only when enabled, data is present and the delayed
    // full_n allows it.
    assign src_read = en & src_empty_n & full_ok_s;

    // Forward pipe next state: unconditional shift, stage 0 takes the read.
    always_comb begin
        valid_d    = valid_q;
        data_d     = data_q;
        valid_d[0] = src_read;
        data_d[0]  = src_dout;
        for (int k = 1; k < PIPE_DEPTH; k++) begin
            valid_d[k] = valid_q[k-1];
            data_d[k]  = data_q[k-1];
        end
    end

    // The count includes the word being presented, so it agrees with
    // dst_write in the same cycle. It wraps naturally at 2^32.
    always_comb begin
        if (valid_d[PIPE_DEPTH-1]) begin
            sent_count_d = sent_count_q + 32'd1;
        end else begin
            sent_count_d = sent_count_q;
        end
    end

    // Forward pipe and counter registers. Reset discards in-flight words.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q      <= '0;
            sent_count_q <= 32'd0;
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q      <= valid_d;
            data_q       <= data_d;
            sent_count_q <= sent_count_d;
        end
    end

    assign dst_write  = valid_q[PIPE_DEPTH-1];
    assign dst_din    = data_q[PIPE_DEPTH-1];
    assign sent_count = sent_count_q;
    assign idle       = ~src_read & ~(|valid_q);

endmodule

// File: tb/tb_fifo_almost_full_tx.sv
// Self-checking bench for fifo_almost_full_tx. A source FIFO model feeds
// the DUT. Every popped word goes into a scoreboard with the cycle on which
// it must appear downstream. A separate monitor compares each dst_write
// against that queue and pushes the word into a 16-deep almost-full FIFO
// model. That model produces dst_full_n and flags any overflow.
module tb_fifo_almost_full_tx;
    localparam int DW        = 32;
    localparam int PIPE      = 2;
    localparam int BACK      = 1;
    localparam int GRACE     = 4;
    localparam int DST_DEPTH = 16;

    typedef struct {
        logic [DW-1:0] d;
        int            due;
    } ent_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          en = 1'b0;
    logic          src_empty_n = 1'b0;
    logic [DW-1:0] src_dout = '0;
    logic          dst_full_n = 1'b0;
    logic          src_read;
    logic          dst_write;
    logic [DW-1:0] dst_din;
    logic [31:0]   sent_count;
    logic          idle;

    bit            clk_run = 1'b0;
    int            cyc = 0;
    int            total = 0;
    int            bad = 0;

    ent_t          exp_q[$];
    logic [DW-1:0] src_q[$];
    logic [DW-1:0] dst_fifo[$];
    int            exp_sent = 0;
    int            last_pop = -1000;
    bit            force_prev0 = 1'b0;
    bit            en_v = 1'b0;
    bit            reader_en = 1'b1;
    logic          prev_full = 1'b0;

    fifo_almost_full_tx #(
        .DATA_WIDTH(DW), .PIPE_DEPTH(PIPE), .BACK_DEPTH(BACK), .DST_GRACE(GRACE)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .src_empty_n(src_empty_n),
        .src_dout(src_dout), .src_read(src_read), .dst_full_n(dst_full_n),
        .dst_write(dst_write), .dst_din(dst_din), .sent_count(sent_count),
        .idle(idle)
    );

    initial begin
        forever begin
            #5;
            if (clk_run) clk = ~clk;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Monitor: registered outputs are stable at the falling edge.
    always @(negedge clk) begin
        if (reset) begin
            if (dst_write) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", {32'd0, dst_din}, 64'hDEAD);
                end else begin
                    ent_t e;
                    e = exp_q.pop_front();
                    chk("write_data", {32'd0, dst_din}, {32'd0, e.d});
                    chk("write_latency", cyc, e.due);
                end
                exp_sent++;
                chk("dst_no_overflow", (dst_fifo.size() < DST_DEPTH), 1);
                if (dst_fifo.size() < DST_DEPTH) dst_fifo.push_back(dst_din);
            end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                chk("missing_write", 0, 1);
                void'(exp_q.pop_front());
            end
            chk("sent_count", sent_count, exp_sent);
        end
    end

    // One cycle of stimulus: drive inputs after the falling edge, then
    // check the combinational outputs and model the source pop.
    task automatic step();
        logic exp_read;
        logic exp_idle;
        @(negedge clk);
        #1;
        if (reader_en && dst_fifo.size() > 0) void'(dst_fifo.pop_front());
        prev_full = force_prev0 ? 1'b0 : dst_full_n;
        force_prev0 = 1'b0;
        dst_full_n = (dst_fifo.size() < DST_DEPTH - GRACE);
        en = en_v;
        src_empty_n = (src_q.size() > 0);
        src_dout = src_empty_n ? src_q[0] : '0;
        #2;
        exp_read = en & src_empty_n & prev_full;
        chk("src_read", src_read, exp_read);
        exp_idle = !exp_read && !(last_pop <= cyc && cyc <= last_pop + PIPE - 1);
        chk("idle", idle, exp_idle);
        if (src_read) begin
            ent_t e;
            e.d = src_q.pop_front();
            e.due = cyc + PIPE;
            exp_q.push_back(e);
            last_pop = cyc + 1;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Asynchronous reset asserted mid-cycle, spanning one rising edge.
    task automatic reset_mid();
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_dst_write", dst_write, 0);
        chk("rst_dst_din", dst_din, 0);
        chk("rst_sent_count", sent_count, 0);
        chk("rst_src_read", src_read, 0);
        chk("rst_idle", idle, 1);
        exp_q.delete();
        exp_sent = 0;
        last_pop = -1000;
        force_prev0 = 1'b1;
        #3;
        reset = 1'b1;
    endtask

    initial begin
        // Reset with no clock running.
        #1;
        chk("init_dst_write", dst_write, 0);
        chk("init_dst_din", dst_din, 0);
        chk("init_src_read", src_read, 0);
        chk("init_sent_count", sent_count, 0);
        chk("init_idle", idle, 1);
        clk_run = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        reset = 1'b1;
        run(3);

        // Single word.
        en_v = 1'b1;
        src_q.push_back(32'hA5A5_0001);
        run(6);

        // 100-word incrementing burst, reader always draining.
        for (int i = 0; i < 100; i++) src_q.push_back(i);
        run(110);

        // Reader stalled during a 40-word burst, then resumed.
        reader_en = 1'b0;
        for (int i = 0; i < 40; i++) src_q.push_back($urandom);
        run(30);
        reader_en = 1'b1;
        run(60);

        // en low for 5 cycles mid-burst.
        for (int i = 0; i < 20; i++) src_q.push_back(32'h1000_0000 + i);
        run(5);
        en_v = 1'b0;
        run(5);
        en_v = 1'b1;
        run(20);

        // Asynchronous reset with words in flight.
        for (int i = 0; i < 20; i++) src_q.push_back(32'h2000_0000 + i);
        run(5);
        reset_mid();
        run(30);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            en_v = ($urandom_range(0, 9) != 0);
            reader_en = ($urandom_range(0, 3) != 0);
            if (src_q.size() < 8 && $urandom_range(0, 1) == 1) src_q.push_back($urandom);
            step();
        end

        // Drain everything.
        en_v = 1'b1;
        reader_en = 1'b1;
        run(40);
        chk("drained_scoreboard", exp_q.size(), 0);
        chk("drained_source", src_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
